tsfm_bridge: RTL and testbench
==============================

# tsfm_bridge

Parametrised TurboSound-FM style front-end for NUM_CHIPS YM2203-class sound cores (each a 3-channel FM+SSG core on a 1-bit address bus). It decodes chip-select/control writes on the CPU port, routes bus cycles to the selected core, and muxes its read data back. It also time-multiplexes the cores' signed sample outputs into one saturated mix with its own sample strobe. It sits between the CPU I/O decoder and the cores; the audio DAC path consumes `snd`/`snd_sample`.

## Interface
Parameters:
- NUM_CHIPS, 2, number of attached cores, 1..8
- SND_W, 16, per-core and mixed sample width (signed)

Ports:
- clk  in  1  system clock; one clock for the whole block
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable shared with the cores; gates CPU-port decoding only
- din  in  8  CPU write data
- addr  in  1  0 = register-address port, 1 = data port
- cs_n  in  1  CPU chip select, active low
- wr_n  in  1  CPU write strobe, active low
- dout  out  8  read data of the selected core, registered
- chip_cs_n  out  NUM_CHIPS  per-core select, active low
- chip_ay_mode  out  NUM_CHIPS  per-core FM-disable bit
- chip_dout  in  8*NUM_CHIPS  per-core read data, core k at [8k+7:8k]
- chip_snd  in  SND_W*NUM_CHIPS  per-core signed sample
- chip_sample  in  NUM_CHIPS  per-core sample strobe; only bit 0 is used as mix timebase
- sel  out  3  index of the currently selected core
- snd  out  SND_W  signed saturated mix
- snd_sample  out  1  one-clk strobe, `snd` valid
- overrun  out  1  sticky: a timebase strobe arrived while mixing

## Operation
- CPU write: cycle with cen=1, cs_n=0, wr_n=0.
- Control write: CPU write with addr=0 and din[7:4]=4'hF. It is NOT forwarded; all chip_cs_n stay 1 that cycle.
  - din[2:0] = new index. It is accepted only if < NUM_CHIPS; otherwise sel is unchanged.
  - din[3] is written to chip_ay_mode[new index] when that index is accepted.
- All other accesses, reads included: chip_cs_n[sel]=cs_n and other bits=1, combinationally. din, addr and wr_n fan out to the cores unchanged, outside this block.
- dout: registered every cen=1 cycle from chip_dout[sel]. It holds when cen=0.
- Mixer FSM, runs every clk independent of cen:
  - IDLE: on chip_sample[0]=1, clear acc, i=0 -> ACC.
  - ACC: acc += sign-extended chip_snd[i]; i++. After i=NUM_CHIPS-1 -> OUT.
  - OUT: snd <= sat(acc); snd_sample=1 for this one clk -> IDLE.
- Arithmetic: acc width is SND_W+3 signed. sat clamps to [-2^(SND_W-1), 2^(SND_W-1)-1].
- Samples are taken live during ACC; cores hold chip_snd stable for ≥NUM_CHIPS+2 clk after their strobe.
- chip_sample[0] seen in ACC or OUT: overrun<=1, the strobe is dropped and the current mix completes.
- A chip_sample[0] in the same cycle the FSM returns to IDLE (OUT cycle) counts as overrun.

## Timing
- Reset values: sel=0, chip_ay_mode=0, dout=0, snd=0, snd_sample=0, overrun=0, FSM=IDLE, acc=0. chip_cs_n follows cs_n for core 0.
- Reset mid-mix aborts: no snd_sample and snd stays 0.
- Control write takes effect the clk after it; a forwarded access in the next cen cycle goes to the new core.
- Mix latency: chip_sample[0] at cycle t gives snd_sample at t+NUM_CHIPS+1.
  - Cycle t: IDLE→ACC. Cycles t+1..t+NUM_CHIPS: ACC. Cycle t+NUM_CHIPS+1: OUT, with snd updated the same edge snd_sample rises.
- Maximum sustained strobe rate: one per NUM_CHIPS+2 clk.
- dout latency: one cen-qualified clk.

## Test plan
- Reset, then write addr=0 din=8'hF9 -> sel=1, chip_ay_mode=2'b10, all chip_cs_n=1 during the write; next data write asserts only chip_cs_n[1].
- NUM_CHIPS=2, write din=8'hF5 -> index 5 rejected: sel stays at its previous value, chip_ay_mode unchanged.
- chip_snd = {16'sd1000, -16'sd300}, pulse chip_sample[0] at t -> snd=700 with snd_sample high only at t+3.
- chip_snd both 16'sd30000 -> snd=32767; both -16'sd30000 -> snd=-32768.
- Second chip_sample[0] 2 clk after the first -> overrun=1, exactly one snd_sample. overrun stays 1 until rst.
- Assert rst during ACC -> no snd_sample, snd=0, FSM IDLE. The next strobe after rst produces a correct mix.

Source files
------------

// File: rtl/tsfm_bridge.sv
// TurboSound-FM style front-end: chip-select decode, read-data mux and a
// time-multiplexed saturating mixer for NUM_CHIPS YM2203-class cores.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for the core-0 sample strobe
// ST_ACC  | adding one core sample per clk into acc
// ST_OUT  | snd/snd_sample valid for this clk, then back to idle
module tsfm_bridge #(
   parameter int NUM_CHIPS = 2,
   parameter int SND_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cen,
   input  logic [7:0]                   din,
   input  logic                         addr,
   input  logic                         cs_n,
   input  logic                         wr_n,
   output logic [7:0]                   dout,
   output logic [NUM_CHIPS-1:0]         chip_cs_n,
   output logic [NUM_CHIPS-1:0]         chip_ay_mode,
   input  logic [8*NUM_CHIPS-1:0]       chip_dout,
   input  logic [SND_W*NUM_CHIPS-1:0]   chip_snd,
   input  logic [NUM_CHIPS-1:0]         chip_sample,
   output logic [2:0]                   sel,
   output logic signed [SND_W-1:0]      snd,
   output logic                         snd_sample,
   output logic                         overrun
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_t;

   localparam int AW = SND_W + 3;
   localparam logic [2:0] LAST_IDX = 3'(NUM_CHIPS - 1);
   localparam logic signed [AW-1:0] SAT_MAX = {{4{1'b0}}, {(SND_W-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{4{1'b1}}, {(SND_W-1){1'b0}}};

   state_t                  state_q, state_d;
   logic [2:0]              idx_q, idx_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic signed [SND_W-1:0] snd_q, snd_d;
   logic                    snd_sample_q, snd_sample_d;
   logic                    overrun_q, overrun_d;
   logic [2:0]              sel_q, sel_d;
   logic [NUM_CHIPS-1:0]    ay_q, ay_d;
   logic [7:0]              dout_q, dout_d;

   logic                    cpu_wr, ctrl_wr, strobe;
   logic [7:0]              rd_mux;
   logic signed [SND_W-1:0] samp;
   logic signed [AW-1:0]    acc_sum, sat_v;
   logic                    unused_sample;

   // Only core 0 paces the mixer; the other strobes are intentionally ignored.
   assign unused_sample = ^chip_sample;
   assign strobe        = chip_sample[0];

   always_comb begin
      cpu_wr  = cen & ~cs_n & ~wr_n;
      ctrl_wr = cpu_wr & ~addr & (din[7:4] == 4'hF);

      sel_d = sel_q;
      ay_d  = ay_q;
      if (ctrl_wr && (32'(din[2:0]) < NUM_CHIPS)) begin
         sel_d = din[2:0];
         for (int k = 0; k < NUM_CHIPS; k++)
            if (din[2:0] == 3'(k)) ay_d[k] = din[3];
      end

      chip_cs_n = '1;
      rd_mux    = 8'h00;
      samp      = '0;
      for (int k = 0; k < NUM_CHIPS; k++) begin
         if (!ctrl_wr && sel_q == 3'(k)) chip_cs_n[k] = cs_n;
         if (sel_q == 3'(k)) rd_mux = chip_dout[8*k +: 8];
         if (idx_q == 3'(k)) samp = chip_snd[SND_W*k +: SND_W];
      end
      dout_d = cen ? rd_mux : dout_q;

      acc_sum = acc_q + {{3{samp[SND_W-1]}}, samp};
      if (acc_sum > SAT_MAX)      sat_v = SAT_MAX;
      else if (acc_sum < SAT_MIN) sat_v = SAT_MIN;
      else                        sat_v = acc_sum;

      state_d      = state_q;
      idx_d        = idx_q;
      acc_d        = acc_q;
      snd_d        = snd_q;
      snd_sample_d = 1'b0;
      overrun_d    = overrun_q | (strobe && state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (strobe) begin
               acc_d   = '0;
               idx_d   = 3'd0;
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            acc_d = acc_sum;
            idx_d = idx_q + 3'd1;
            // Saturate the final sum on the way into OUT so snd and
            // snd_sample are both registered and rise on the same edge.
            if (idx_q == LAST_IDX) begin
               snd_d        = sat_v[SND_W-1:0];
               snd_sample_d = 1'b1;
               state_d      = ST_OUT;
            end
         end
         ST_OUT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 3'd0;
         acc_q        <= '0;
         snd_q        <= '0;
         snd_sample_q <= 1'b0;
         overrun_q    <= 1'b0;
         sel_q        <= 3'd0;
         ay_q         <= '0;
         dout_q       <= 8'h00;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         snd_q        <= snd_d;
         snd_sample_q <= snd_sample_d;
         overrun_q    <= overrun_d;
         sel_q        <= sel_d;
         ay_q         <= ay_d;
         dout_q       <= dout_d;
      end
   end

   assign dout         = dout_q;
   assign chip_ay_mode = ay_q;
   assign sel          = sel_q;
   assign snd          = snd_q;
   assign snd_sample   = snd_sample_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_tsfm_bridge.sv
// Directed bench for tsfm_bridge (NUM_CHIPS=2, SND_W=16): CPU decode, read
// mux and mixer, with expected mix results held in a scoreboard queue.
module tb_tsfm_bridge;
   logic               clk, rst, cen, addr, cs_n, wr_n;
   logic [7:0]         din, dout;
   logic [1:0]         chip_cs_n, chip_ay_mode, chip_sample;
   logic [15:0]        chip_dout;
   logic [31:0]        chip_snd;
   logic [2:0]         sel;
   logic signed [15:0] snd;
   logic               snd_sample, overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   int p0;
   logic [1:0] cs_seen;
   int exp_q[$];

   tsfm_bridge #(.NUM_CHIPS(2), .SND_W(16)) dut (
      .clk(clk), .rst(rst), .cen(cen), .din(din), .addr(addr), .cs_n(cs_n),
      .wr_n(wr_n), .dout(dout), .chip_cs_n(chip_cs_n),
      .chip_ay_mode(chip_ay_mode), .chip_dout(chip_dout),
      .chip_snd(chip_snd), .chip_sample(chip_sample), .sel(sel), .snd(snd),
      .snd_sample(snd_sample), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (snd_sample === 1'b1) pulses++;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic a, input logic [7:0] d,
                            output logic [1:0] cs_obs);
      cen = 1'b1; cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
      #1;
      cs_obs = chip_cs_n;
      step();
      cs_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic do_mix(input logic signed [15:0] s0, input logic signed [15:0] s1);
      int sum, n, e;
      sum = int'(s0) + int'(s1);
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      exp_q.push_back(sum);
      chip_snd    = {s1, s0};
      chip_sample = 2'b01;
      step();
      chip_sample = 2'b00;
      n = 1;
      while (snd_sample !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("mix_latency", n, 3);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
      chk("mix_snd", snd, e);
      step();
      chk("mix_strobe_one_clk", snd_sample, 0);
   endtask

   initial begin
      rst = 1'b1; cen = 1'b1; addr = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
      din = 8'h00; chip_dout = 16'hB2A1; chip_snd = '0; chip_sample = 2'b00;
      step(); step();
      rst = 1'b0;
      cs_n = 1'b0;
      #1;
      chk("rst_sel", sel, 0);
      chk("rst_ay", chip_ay_mode, 0);
      chk("rst_dout", dout, 0);
      chk("rst_snd", snd, 0);
      chk("rst_snd_sample", snd_sample, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_cs_core0", chip_cs_n, 2'b10);
      cs_n = 1'b1;
      step();

      cpu_write(1'b0, 8'hF9, cs_seen);
      chk("ctrl_cs_all_high", cs_seen, 2'b11);
      chk("ctrl_sel1", sel, 1);
      chk("ctrl_ay10", chip_ay_mode, 2'b10);
      cpu_write(1'b1, 8'h12, cs_seen);
      chk("data_cs_core1", cs_seen, 2'b01);

      cpu_write(1'b0, 8'hF5, cs_seen);
      chk("reject_sel", sel, 1);
      chk("reject_ay", chip_ay_mode, 2'b10);
      cpu_write(1'b0, 8'hF8, cs_seen);
      chk("ctrl_sel0", sel, 0);
      chk("ctrl_ay11", chip_ay_mode, 2'b11);
      cpu_write(1'b0, 8'hF1, cs_seen);
      chk("ctrl_sel1b", sel, 1);
      chk("ctrl_ay01", chip_ay_mode, 2'b01);

      cen = 1'b1;
      step();
      chk("dout_core1", dout, 8'hB2);
      cen = 1'b0; chip_dout = 16'h5566;
      step();
      chk("dout_hold", dout, 8'hB2);
      cs_n = 1'b0; wr_n = 1'b0; addr = 1'b0; din = 8'hF8;
      step();
      cs_n = 1'b1; wr_n = 1'b1;
      chk("ctrl_no_cen", sel, 1);
      cen = 1'b1;
      step();
      chk("dout_new", dout, 8'h55);

      do_mix(16'sd1000, -16'sd300);
      do_mix(16'sd30000, 16'sd30000);
      do_mix(-16'sd30000, -16'sd30000);
      do_mix(-16'sd1000, -16'sd300);
      chk("no_overrun_yet", overrun, 0);

      p0 = pulses;
      exp_q.push_back(1100);
      chip_snd = {16'sd600, 16'sd500};
      chip_sample = 2'b01;
      step();
      chip_sample = 2'b00;
      step();
      chip_sample = 2'b01;
      step();
      chip_sample = 2'b00;
      chk("ovr_snd_sample", snd_sample, 1);
      chk("ovr_snd", snd, (exp_q.size() > 0) ? exp_q.pop_front() : 0);
      chk("ovr_flag", overrun, 1);
      repeat (4) step();
      chk("ovr_one_pulse", pulses - p0, 1);
      do_mix(16'sd250, 16'sd250);
      chk("ovr_sticky", overrun, 1);

      p0 = pulses;
      chip_snd = {16'sd200, 16'sd100};
      chip_sample = 2'b01;
      step();
      chip_sample = 2'b00;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_snd_sample", snd_sample, 0);
      chk("abort_snd", snd, 0);
      chk("abort_overrun", overrun, 0);
      repeat (4) step();
      chk("abort_no_pulse", pulses - p0, 0);
      chk("abort_snd_hold", snd, 0);
      do_mix(16'sd1000, -16'sd300);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
